// File: rtl/earom_ctrl.sv
// EAROM access sequencer: runs read, write, erase and program (erase+write)
// cycles with programmable setup, strobe and hold phase lengths.
module earom_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [1:0] cmd,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [5:0] ea_a,
  output logic [7:0] ea_din,
  output logic       ea_c1,
  output logic       ea_c2,
  output logic       ea_cs1,
  output logic       ea_rclk,
  input  logic [7:0] ea_dout
);

  // A zero-length phase would skip the EAROM timing entirely, so clamp to 1.
  localparam int SU_EFF = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int ST_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int HD_EFF = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

  localparam logic [7:0] SU_LOAD = 8'(SU_EFF - 1);
  localparam logic [7:0] ST_LOAD = 8'(ST_EFF - 1);
  localparam logic [7:0] HD_LOAD = 8'(HD_EFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RDCLK,
    RDCAP,
    HOLD,
    DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_isRead;
  logic       r_progWrite;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_isRead    <= 1'b0;
      r_progWrite <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= 8'h00;
      ea_a        <= 6'd0;
      ea_din      <= 8'h00;
      ea_c1       <= 1'b1;
      ea_c2       <= 1'b1;
      ea_cs1      <= 1'b0;
      ea_rclk     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_state     <= SETUP;
            r_cnt       <= SU_LOAD;
            busy        <= 1'b1;
            ea_a        <= addr;
            ea_din      <= wdata;
            r_isRead    <= (cmd == 2'b00);
            r_progWrite <= (cmd == 2'b11);
            // read 1/0, write 0/0, erase and the first program pass 0/1
            ea_c1       <= (cmd == 2'b00);
            ea_c2       <= cmd[1];
          end
        end
        SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state <= STROBE;
            r_cnt   <= ST_LOAD;
            ea_cs1  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 8'd0) begin
            if (r_isRead) begin
              r_state <= RDCLK;
              ea_rclk <= 1'b1;
            end else begin
              r_state <= HOLD;
              r_cnt   <= HD_LOAD;
              ea_cs1  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RDCLK: begin
          r_state <= RDCAP;
          ea_rclk <= 1'b0;
        end
        RDCAP: begin
          r_state <= HOLD;
          r_cnt   <= HD_LOAD;
          ea_cs1  <= 1'b0;
          rdata   <= ea_dout;
        end
        HOLD: begin
          if (r_cnt == 8'd0) begin
            if (r_progWrite) begin
              // Program: erase pass finished, rerun the phases as a write.
              r_progWrite <= 1'b0;
              r_state     <= SETUP;
              r_cnt       <= SU_LOAD;
              ea_c2       <= 1'b0;
            end else begin
              r_state <= DONE;
              ea_c1   <= 1'b1;
              ea_c2   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_earom_ctrl.sv
// Randomized bench for earom_ctrl: a cycle-timeline model of each accepted
// command plus a behavioural EAROM array, with directed literal checks.
module tb_earom_ctrl;

  localparam int SU = 2;
  localparam int ST = 4;
  localparam int HD = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [5:0] addr = 6'd0;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ea_c1, ea_c2, ea_cs1, ea_rclk;
  logic [7:0] rdata, ea_din, ea_dout;
  logic [5:0] ea_a;

  logic       fReq = 1'b0;
  logic [1:0] fCmd = 2'b00;
  logic [5:0] fAddr = 6'd0;
  logic [7:0] fWdata = 8'h00;
  logic [7:0] fDout = 8'h00;
  logic       fBusy, fDone, fC1, fC2, fCs1, fRclk;
  logic [7:0] fRdata, fEaDin;
  logic [5:0] fEaA;

  int nVectors = 0;
  int nMiscompares = 0;
  logic checkOn = 1'b0;
  logic initDone = 1'b0;
  logic memLoaded = 1'b0;
  logic earomLoaded = 1'b0;
  logic [7:0] initMem [64];
  logic [7:0] expMem [64];
  logic [7:0] earom [64];

  logic       mActive = 1'b0;
  logic       mDone = 1'b0;
  int         mAge = 0;
  logic [1:0] mCmd = 2'b00;
  logic [5:0] mAddr = 6'd0;
  logic [7:0] mData = 8'h00;
  logic [7:0] expRdata = 8'h00;
  logic [5:0] lastAddr = 6'd0;
  logic [7:0] lastDin = 8'h00;

  logic eBusy, eDone, eCs, eRclk, eC1, eC2;
  int   cLen, cIdx, cOff;

  always #5 clk = ~clk;

  earom_ctrl #(.SETUP_CYC(SU), .STROBE_CYC(ST), .HOLD_CYC(HD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cmd(cmd), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .ea_a(ea_a),
    .ea_din(ea_din), .ea_c1(ea_c1), .ea_c2(ea_c2), .ea_cs1(ea_cs1),
    .ea_rclk(ea_rclk), .ea_dout(ea_dout)
  );

  earom_ctrl #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dutFast (
    .clk(clk), .reset_n(reset_n), .req(fReq), .cmd(fCmd), .addr(fAddr),
    .wdata(fWdata), .busy(fBusy), .done(fDone), .rdata(fRdata), .ea_a(fEaA),
    .ea_din(fEaDin), .ea_c1(fC1), .ea_c2(fC2), .ea_cs1(fCs1),
    .ea_rclk(fRclk), .ea_dout(fDout)
  );

  // Pin-level EAROM stand-in: a strobe with c1=0 writes (c2=0) or erases (c2=1).
  assign ea_dout = earom[ea_a];

  always @(negedge clk) begin
    if (!earomLoaded) begin
      if (initDone) begin
        for (int i = 0; i < 64; i++) earom[i] = initMem[i];
        earomLoaded = 1'b1;
      end
    end else if (ea_cs1 && !ea_c1) begin
      earom[ea_a] = ea_c2 ? 8'hFF : ea_din;
    end
  end

  function automatic int latency(input logic [1:0] c);
    int base;
    base = SU + ST + HD;
    case (c)
      2'b00:   return base + 3;
      2'b11:   return 2 * base + 1;
      default: return base + 1;
    endcase
  endfunction

  // Command-level model: mAge counts clock edges since the acceptance edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (!memLoaded && initDone) begin
        for (int i = 0; i < 64; i++) expMem[i] = initMem[i];
        memLoaded = 1'b1;
      end
      mActive = 1'b0; mDone = 1'b0; mAge = 0;
      expRdata = 8'h00; lastAddr = 6'd0; lastDin = 8'h00;
    end else begin
      mDone = 1'b0;
      if (mActive) begin
        mAge++;
        if (mCmd == 2'b00 && mAge == SU + ST + 2) expRdata = expMem[mAddr];
        if (mAge == latency(mCmd)) begin
          mActive = 1'b0;
          mDone   = 1'b1;
          if (mCmd == 2'b10) expMem[mAddr] = 8'hFF;
          else if (mCmd != 2'b00) expMem[mAddr] = mData;
        end
      end else if (req) begin
        mActive = 1'b1; mAge = 0; mCmd = cmd; mAddr = addr; mData = wdata;
        lastAddr = addr; lastDin = wdata;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn && reset_n) begin
      eBusy = 1'b0; eDone = mDone; eCs = 1'b0; eRclk = 1'b0; eC1 = 1'b1; eC2 = 1'b1;
      if (mActive) begin
        eBusy = 1'b1;
        eDone = 1'b0;
        if (mAge < latency(mCmd) - 1) begin
          cLen = SU + ST + HD + ((mCmd == 2'b00) ? 2 : 0);
          cIdx = mAge / cLen;
          cOff = mAge % cLen;
          case (mCmd)
            2'b00:   begin eC1 = 1'b1; eC2 = 1'b0; end
            2'b01:   begin eC1 = 1'b0; eC2 = 1'b0; end
            2'b10:   begin eC1 = 1'b0; eC2 = 1'b1; end
            default: begin eC1 = 1'b0; eC2 = (cIdx == 0); end
          endcase
          eCs   = (cOff >= SU) && (cOff < cLen - HD);
          eRclk = (mCmd == 2'b00) && (cOff == SU + ST);
        end
      end
      checkOutput("busy", busy, eBusy);
      checkOutput("done", done, eDone);
      checkOutput("ea_cs1", ea_cs1, eCs);
      checkOutput("ea_rclk", ea_rclk, eRclk);
      checkOutput("ea_c1", ea_c1, eC1);
      checkOutput("ea_c2", ea_c2, eC2);
      checkOutput("ea_a", ea_a, lastAddr);
      checkOutput("ea_din", ea_din, lastDin);
      checkOutput("rdata", rdata, expRdata);
    end
  end

  // Issue one command from an idle controller and profile it until done.
  task automatic applyStimulus(input logic [1:0] c, input logic [5:0] a, input logic [7:0] d,
                               output int lat, output int csE, output int csW,
                               output int csR, output int rk);
    req = 1'b1; cmd = c; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = -1; csE = 0; csW = 0; csR = 0; rk = 0;
    for (int k = 0; k < 100; k++) begin
      if (ea_cs1) begin
        if (ea_c1 && !ea_c2) csR++;
        else if (!ea_c1 && !ea_c2) csW++;
        else if (!ea_c1 && ea_c2) csE++;
      end
      if (ea_rclk) rk++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
  endtask

  int lat, csE, csW, csR, rk, first, second, fLat, fCs;

  initial begin
    for (int i = 0; i < 64; i++) initMem[i] = 8'($urandom);
    initMem[6'h3F] = 8'hFF;
    initDone = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_ea_a", ea_a, 0);
    checkOutput("rst_ea_din", ea_din, 0);
    checkOutput("rst_c1c2", {ea_c1, ea_c2}, 2'b11);
    checkOutput("rst_cs1_rclk", {ea_cs1, ea_rclk}, 2'b00);
    reset_n = 1'b1;
    checkOn = 1'b1;
    @(negedge clk);

    applyStimulus(2'b01, 6'h05, 8'hA5, lat, csE, csW, csR, rk);
    checkOutput("wr_latency", lat, 9);
    checkOutput("wr_strobe_c00", csW, 4);
    checkOutput("wr_no_erase", csE, 0);

    applyStimulus(2'b00, 6'h05, 8'h00, lat, csE, csW, csR, rk);
    checkOutput("rd_latency", lat, 11);
    checkOutput("rd_rclk_pulses", rk, 1);
    checkOutput("rd_strobe_c10", csR, 6);
    checkOutput("rd_data", rdata, 8'hA5);

    applyStimulus(2'b11, 6'h3F, 8'h3C, lat, csE, csW, csR, rk);
    checkOutput("prog_latency", lat, 17);
    checkOutput("prog_erase_strobe", csE, 4);
    checkOutput("prog_write_strobe", csW, 4);
    applyStimulus(2'b00, 6'h3F, 8'h00, lat, csE, csW, csR, rk);
    checkOutput("prog_readback", rdata, 8'h3C);

    // req held high; addr/wdata churn while busy must be ignored.
    req = 1'b1; cmd = 2'b01; addr = 6'h10; wdata = 8'h11;
    @(posedge clk);
    @(negedge clk);
    first = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        first = k;
        break;
      end
      addr = 6'($urandom); wdata = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("b2b_first_done", first, 9);
    addr = 6'h20; wdata = 8'h22;
    @(negedge clk);
    req = 1'b0;
    checkOutput("b2b_accepted", busy, 1);
    second = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        second = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("b2b_second_done", second, 9);
    applyStimulus(2'b00, 6'h10, 8'h00, lat, csE, csW, csR, rk);
    checkOutput("b2b_cell10", rdata, 8'h11);
    applyStimulus(2'b00, 6'h20, 8'h00, lat, csE, csW, csR, rk);
    checkOutput("b2b_cell20", rdata, 8'h22);

    // Reset during a write strobe; rewriting cell 5 with its own value keeps
    // the array consistent however far the aborted access got.
    req = 1'b1; cmd = 2'b01; addr = 6'h05; wdata = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      if (ea_cs1) begin
        first = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rst_test_strobe_seen", (first >= 0), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_cs1", ea_cs1, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    checkOutput("async_rdata", rdata, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_no_done", done, 0);
    end
    reset_n = 1'b1;
    repeat (12) @(negedge clk);

    fReq = 1'b1; fCmd = 2'b01; fAddr = 6'h2A; fWdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    fReq = 1'b0;
    fLat = -1; fCs = 0;
    for (int k = 0; k < 20; k++) begin
      if (fCs1) fCs++;
      if (fDone) begin
        fLat = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("fast_latency", fLat, 4);
    checkOutput("fast_strobe", fCs, 1);
    checkOutput("fast_ea_a", fEaA, 6'h2A);
    checkOutput("fast_ea_din", fEaDin, 8'h5A);
    checkOutput("fast_idle_pins", {fBusy, fC1, fC2, fRclk}, 4'b0110);
    checkOutput("fast_rdata", fRdata, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      cmd   = 2'($urandom);
      addr  = 6'($urandom);
      wdata = 8'($urandom);
      @(negedge clk);
    end
    req = 1'b0;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
